decoupled_fetch_unit: RTL and testbench
=======================================

// Module: decoupled_fetch_unit
// PURPOSE
//  Parametrised next-generation fetch unit: issues word addresses to the I$, pre-decodes each hit, predicts
//  nPC via a tagged BTB with 2-bit DIRP counters, an immediate j/jal path and a RAS. Each fetched instruction
//  is buffered in a FETCH_Q_DEPTH-entry fetch queue, so I$ fetch is decoupled from pipeline back-pressure.
//  Sits between the I$ and the decode/dispatch stage inside core.
// PARAMETERS
//  PC_RESET_VAL   16'h0  byte reset address; PC register holds bits [PC_WIDTH+1:2]
//  PC_WIDTH       14     word-granular PC width
//  BTB_FRAMES     16     BTB/DIRP entries (power of 2); LOG_BTB = $clog2(BTB_FRAMES)
//  RAS_DEPTH      8      RAS entries (power of 2); circular, overwrites oldest entry
//  FETCH_Q_DEPTH  4      fetch queue entries (power of 2, >=2)
// PORTS
//  CLK                            in   1         clock
//  nRST                           in   1         reset, asynchronous, active-low
//  from_pipeline_BTB_DIRP_update  in   1         write BTB/DIRP entry this cycle
//  from_pipeline_BTB_DIRP_PC      in   PC_WIDTH  PC of the resolved branch (provides index and tag)
//  from_pipeline_BTB_target       in   PC_WIDTH  resolved branch target
//  from_pipeline_DIRP_taken       in   1         resolved direction
//  from_pipeline_take_resolved    in   1         redirect/flush
//  from_pipeline_resolved_PC      in   PC_WIDTH  redirect target
//  from_pipeline_resolved_RAS_ptr in   $clog2(RAS_DEPTH)  RAS top to restore (FETCH_RAS_RESTORE_EN only)
//  icache_hit / icache_load       in   1 / 32    I$ response, same cycle as request
//  icache_REN / icache_halt       out  1 / 1     I$ read enable / halt request
//  icache_addr                    out  32        {16'h0, PC, 2'b00}
//  core_control_halt              in   1         halt fetch
//  to_pipeline_ivalid             out  1         FQ head valid
//  to_pipeline_ready              in   1         pipeline accepts head this cycle
//  to_pipeline_instr / _PC / _nPC out  32 / PC_WIDTH / PC_WIDTH   FQ head fields
//  to_pipeline_RAS_ptr            out  $clog2(RAS_DEPTH)  RAS top at fetch of head (checkpoint)
// BEHAVIOUR
//  - Reset: PC=PC_RESET_VAL[PC_WIDTH+1:2]; BTB tag/target 0, all DIRP WEAK_NT; RAS entries 0, top ptr 0;
//    FQ empty; icache_halt=0; outputs ivalid=0, instr/PC/nPC/RAS_ptr=0. Reset mid-operation discards all state.
//  - icache_REN = ~core_control_halt & ~fq_full (comb). Accept = icache_hit & icache_REN & ~take_resolved.
//  - On accept: push {instr, PC, nPC, RAS top} to FQ tail; PC<=nPC. No accept: PC holds.
//  - nPC priority: beq/bne with BTB tag match (PC[PC_WIDTH-1:LOG_BTB]) and DIRP>=WEAK_T -> BTB target;
//    j/jal -> instr[PC_WIDTH-1:0]; jr with rs==31 -> RAS[top-1]; else PC+1 (wraps modulo 2^PC_WIDTH).
//    Branch with tag miss predicts PC+1.
//  - jal accepted: RAS[top]<=PC+1, top++ (wraps, overwriting). jr $31 accepted: top-- (wraps; empty stack
//    returns the stale entry, no error). RAS changes only on accept.
//  - DIRP: plain saturating 2-bit counter, taken +1 / not-taken -1, no state skipping. Update writes tag,
//    target, counter at index PC[LOG_BTB-1:0]; a same-cycle read of that index sees the old entry.
//  - FQ: ivalid = ~empty; pop when ivalid & to_pipeline_ready. Full blocks push even with a same-cycle pop.
//    Push and pop in the same cycle when neither full nor empty: count unchanged.
//  - take_resolved: PC<=resolved_PC next cycle; FQ emptied; any hit that cycle discarded; ivalid forced 0
//    that cycle; BTB update in the same cycle still applies.
//  - core_control_halt: REN=0; icache_halt set next cycle, sticky until reset; FQ keeps draining.
// CONFIGURATION
//  FETCH_RAS_RESTORE_EN defined: take_resolved also sets RAS top <= from_pipeline_resolved_RAS_ptr
//    (entries untouched). Undefined: port ignored, RAS top unchanged on redirect.
// TESTING
//  - Reset, REN=1, 6 sequential hits, ready=1: PCs 0..5 drain in order, nPC=PC+1, ivalid 1 cycle after first hit.
//  - ready=0 with FETCH_Q_DEPTH=4: after 4 hits REN=0, PC frozen at 4; ready=1 -> REN re-asserts, entries 0..3 out.
//  - Update PC=0x010 target 0x040 taken twice (WEAK_NT->WEAK_T->STRONG_T); fetch beq @0x010 -> nPC=0x040;
//    beq @0x020 (same index, tag mismatch) -> nPC=0x021.
//  - jal @0x005 to 0x100, then jr $31 @0x100 -> nPC=0x006; 9 nested jal with RAS_DEPTH=8 -> first return wraps.
//  - FQ holding 3 entries, take_resolved=1 with PC 0x200 and hit -> ivalid=0, FQ empty, next fetch addr 0x800.
//  - With macro: jal (top=1), redirect with RAS_ptr=0 -> next jr $31 reads entry 7; without macro reads entry 0.

Source files
------------

// File: rtl/decoupled_fetch_unit.sv
// Decoupled fetch unit: I$ request, pre-decode, BTB/DIRP + j/jal + RAS prediction, fetch queue.
// Optional build macro FETCH_RAS_RESTORE_EN: a redirect also restores the RAS top pointer.
module decoupled_fetch_unit #(
  parameter logic [15:0] PC_RESET_VAL  = 16'h0,
  parameter int          PC_WIDTH      = 14,
  parameter int          BTB_FRAMES    = 16,
  parameter int          RAS_DEPTH     = 8,
  parameter int          FETCH_Q_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         from_pipeline_BTB_DIRP_update,
  input  logic [PC_WIDTH-1:0]          from_pipeline_BTB_DIRP_PC,
  input  logic [PC_WIDTH-1:0]          from_pipeline_BTB_target,
  input  logic                         from_pipeline_DIRP_taken,
  input  logic                         from_pipeline_take_resolved,
  input  logic [PC_WIDTH-1:0]          from_pipeline_resolved_PC,
  input  logic [$clog2(RAS_DEPTH)-1:0] from_pipeline_resolved_RAS_ptr,
  input  logic                         icache_hit,
  input  logic [31:0]                  icache_load,
  output logic                         icache_REN,
  output logic                         icache_halt,
  output logic [31:0]                  icache_addr,
  input  logic                         core_control_halt,
  output logic                         to_pipeline_ivalid,
  input  logic                         to_pipeline_ready,
  output logic [31:0]                  to_pipeline_instr,
  output logic [PC_WIDTH-1:0]          to_pipeline_PC,
  output logic [PC_WIDTH-1:0]          to_pipeline_nPC,
  output logic [$clog2(RAS_DEPTH)-1:0] to_pipeline_RAS_ptr
);

  localparam int LOG_BTB = $clog2(BTB_FRAMES);
  localparam int TAG_W   = PC_WIDTH - LOG_BTB;
  localparam int RAS_W   = $clog2(RAS_DEPTH);
  localparam int FQ_W    = $clog2(FETCH_Q_DEPTH);

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] npc;
    logic [RAS_W-1:0]    ras_ptr;
  } fq_entry_t;

  logic [PC_WIDTH-1:0] pc_q, pc_d, npc, pc_inc;
  logic [TAG_W-1:0]    btb_tag_q    [BTB_FRAMES];
  logic [PC_WIDTH-1:0] btb_target_q [BTB_FRAMES];
  logic [1:0]          dirp_q       [BTB_FRAMES];
  logic [PC_WIDTH-1:0] ras_q        [RAS_DEPTH];
  logic [RAS_W-1:0]    ras_top_q, ras_top_d;
  fq_entry_t           fq_q         [FETCH_Q_DEPTH];
  logic [FQ_W-1:0]     fq_head_q, fq_tail_q;
  logic [FQ_W:0]       fq_count_q, fq_count_d;
  logic                icache_halt_q;

  // Pre-decode of the I$ word (MIPS encoding)
  logic [5:0] opcode, funct;
  logic [4:0] rs;
  logic       is_branch, is_jump, is_jal, is_jr_ra;
  assign opcode    = icache_load[31:26];
  assign rs        = icache_load[25:21];
  assign funct     = icache_load[5:0];
  assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);
  assign is_jump   = (opcode == 6'h02) || (opcode == 6'h03);
  assign is_jal    = (opcode == 6'h03);
  assign is_jr_ra  = (opcode == 6'h00) && (funct == 6'h08) && (rs == 5'd31);

  logic [LOG_BTB-1:0] rd_idx, wr_idx;
  logic               btb_tag_match, predict_taken;
  logic [RAS_W-1:0]   ras_top_m1;
  assign rd_idx        = pc_q[LOG_BTB-1:0];
  assign wr_idx        = from_pipeline_BTB_DIRP_PC[LOG_BTB-1:0];
  assign btb_tag_match = btb_tag_q[rd_idx] == pc_q[PC_WIDTH-1:LOG_BTB];
  assign predict_taken = dirp_q[rd_idx] >= WEAK_T;
  assign ras_top_m1    = ras_top_q - RAS_W'(1);
  assign pc_inc        = pc_q + PC_WIDTH'(1);

  // NOTE: every always_comb output gets a default assignment first so no latch is inferred.
  always_comb begin
    npc = pc_inc;
    if (is_branch && btb_tag_match && predict_taken) npc = btb_target_q[rd_idx];
    else if (is_jump)                                npc = icache_load[PC_WIDTH-1:0];
    else if (is_jr_ra)                               npc = ras_q[ras_top_m1];
  end

  logic fq_full, fq_empty, accept, pop;
  assign fq_full            = fq_count_q == (FQ_W+1)'(FETCH_Q_DEPTH);
  assign fq_empty           = fq_count_q == '0;
  assign icache_REN         = ~core_control_halt & ~fq_full;
  assign accept             = icache_hit & icache_REN & ~from_pipeline_take_resolved;
  assign to_pipeline_ivalid = ~fq_empty & ~from_pipeline_take_resolved;
  assign pop                = to_pipeline_ivalid & to_pipeline_ready;
  assign icache_addr        = {{(30-PC_WIDTH){1'b0}}, pc_q, 2'b00};
  assign icache_halt        = icache_halt_q;

  always_comb begin
    pc_d = pc_q;
    if (from_pipeline_take_resolved) pc_d = from_pipeline_resolved_PC;
    else if (accept)                 pc_d = npc;
  end

  always_comb begin
    ras_top_d = ras_top_q;
    if (accept && is_jal)        ras_top_d = ras_top_q + RAS_W'(1);
    else if (accept && is_jr_ra) ras_top_d = ras_top_m1;
`ifdef FETCH_RAS_RESTORE_EN
    if (from_pipeline_take_resolved) ras_top_d = from_pipeline_resolved_RAS_ptr;
`endif
  end

`ifndef FETCH_RAS_RESTORE_EN
  logic unused_resolved_ras_ptr;
  assign unused_resolved_ras_ptr = ^from_pipeline_resolved_RAS_ptr;
`endif

  always_comb begin
    fq_count_d = fq_count_q;
    if (accept && !pop)      fq_count_d = fq_count_q + (FQ_W+1)'(1);
    else if (!accept && pop) fq_count_d = fq_count_q - (FQ_W+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every always_ff reads pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q          <= PC_RESET_VAL[PC_WIDTH+1:2];
      ras_top_q     <= '0;
      icache_halt_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ras_top_q <= ras_top_d;
      if (core_control_halt) icache_halt_q <= 1'b1;
    end
  end

  // NOTE: the storage arrays are reset because their cleared contents are visible after reset
  // (BTB misses, stale-RAS returns, zero head fields).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_FRAMES; i++) begin
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        dirp_q[i]       <= WEAK_NT;
      end
    end else if (from_pipeline_BTB_DIRP_update) begin
      btb_tag_q[wr_idx]    <= from_pipeline_BTB_DIRP_PC[PC_WIDTH-1:LOG_BTB];
      btb_target_q[wr_idx] <= from_pipeline_BTB_target;
      if (from_pipeline_DIRP_taken) begin
        if (dirp_q[wr_idx] != STRONG_T) dirp_q[wr_idx] <= dirp_q[wr_idx] + 2'd1;
      end else begin
        if (dirp_q[wr_idx] != STRONG_NT) dirp_q[wr_idx] <= dirp_q[wr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (accept && is_jal) begin
      ras_q[ras_top_q] <= pc_inc;
    end
  end

  // Fetch queue: circular buffer, flushed wholesale on a redirect
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FETCH_Q_DEPTH; i++) fq_q[i] <= '0;
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
      fq_count_q <= '0;
    end else if (from_pipeline_take_resolved) begin
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
      fq_count_q <= '0;
    end else begin
      if (accept) begin
        fq_q[fq_tail_q] <= '{instr: icache_load, pc: pc_q, npc: npc, ras_ptr: ras_top_q};
        fq_tail_q       <= fq_tail_q + FQ_W'(1);
      end
      if (pop) fq_head_q <= fq_head_q + FQ_W'(1);
      fq_count_q <= fq_count_d;
    end
  end

  assign to_pipeline_instr   = fq_q[fq_head_q].instr;
  assign to_pipeline_PC      = fq_q[fq_head_q].pc;
  assign to_pipeline_nPC     = fq_q[fq_head_q].npc;
  assign to_pipeline_RAS_ptr = fq_q[fq_head_q].ras_ptr;

endmodule

// File: tb/tb_decoupled_fetch_unit.sv
// Directed bench for decoupled_fetch_unit: expected FQ entries are queued at fetch and compared on pop.
// Honours FETCH_RAS_RESTORE_EN for the redirect-restore expectation.
module tb_decoupled_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BEQ = 32'h1000_0000;
  localparam logic [31:0] BNE = 32'h1400_0000;
  localparam logic [31:0] JAL = 32'h0C00_0000;
  localparam logic [31:0] JR  = 32'h03E0_0008;

  logic        CLK, nRST;
  logic        upd, upd_taken, take, hit, ready, halt;
  logic [13:0] upd_pc, upd_tgt, res_pc, pc_o, npc_o;
  logic [2:0]  res_ras, ras_o;
  logic [31:0] load, addr, instr_o;
  logic        ren, ihalt, ivalid;

  decoupled_fetch_unit dut (
    .CLK(CLK), .nRST(nRST),
    .from_pipeline_BTB_DIRP_update(upd), .from_pipeline_BTB_DIRP_PC(upd_pc),
    .from_pipeline_BTB_target(upd_tgt), .from_pipeline_DIRP_taken(upd_taken),
    .from_pipeline_take_resolved(take), .from_pipeline_resolved_PC(res_pc),
    .from_pipeline_resolved_RAS_ptr(res_ras),
    .icache_hit(hit), .icache_load(load), .icache_REN(ren), .icache_halt(ihalt),
    .icache_addr(addr), .core_control_halt(halt),
    .to_pipeline_ivalid(ivalid), .to_pipeline_ready(ready),
    .to_pipeline_instr(instr_o), .to_pipeline_PC(pc_o), .to_pipeline_nPC(npc_o),
    .to_pipeline_RAS_ptr(ras_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [13:0] pc;
    logic [13:0] npc;
    logic [2:0]  ras;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] m_pc;
  logic [2:0]  m_top;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive the I$ response, check comb outputs, update the scoreboard, advance.
  task automatic step(input logic h, input logic [31:0] ins, input logic [13:0] exp_npc);
    logic exp_ren, exp_valid, do_pop, acc;
    exp_t e;
    hit  = h;
    load = ins;
    #1;
    exp_ren   = !halt && (sb.size() != 4);
    exp_valid = (sb.size() != 0) && !take;
    check("ren", 32'(ren), 32'(exp_ren));
    check("addr", addr, {16'h0, m_pc, 2'b00});
    check("ivalid", 32'(ivalid), 32'(exp_valid));
    do_pop = exp_valid && ready;
    if (do_pop) begin
      e = sb.pop_front();
      check("head_instr", instr_o, e.instr);
      check("head_pc", 32'(pc_o), 32'(e.pc));
      check("head_npc", 32'(npc_o), 32'(e.npc));
      check("head_ras", 32'(ras_o), 32'(e.ras));
    end
    acc = h && exp_ren && !take;
    if (take) begin
      sb.delete();
      m_pc = res_pc;
`ifdef FETCH_RAS_RESTORE_EN
      m_top = res_ras;
`endif
    end else if (acc) begin
      sb.push_back('{instr: ins, pc: m_pc, npc: exp_npc, ras: m_top});
      m_pc = exp_npc;
      if (ins[31:26] == 6'h03) m_top = m_top + 3'd1;
      else if (ins == JR)      m_top = m_top - 3'd1;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, NOP, 14'h0);
  endtask

  task automatic redirect(input logic [13:0] pc);
    take    = 1'b1;
    res_pc  = pc;
    res_ras = m_top;
    idle();
    take    = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; upd = 0; upd_taken = 0; upd_pc = '0; upd_tgt = '0;
    take = 0; res_pc = '0; res_ras = '0; hit = 0; load = '0; ready = 0; halt = 0;
    m_pc = '0; m_top = '0;
    #1;
    check("rst_ivalid", 32'(ivalid), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_npc", 32'(npc_o), 32'd0);
    check("rst_ras", 32'(ras_o), 32'd0);
    check("rst_ihalt", 32'(ihalt), 32'd0);
    check("rst_addr", addr, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Sequential stream, pipeline always ready
    ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, NOP, 14'(i + 1));
    idle();
    idle();

    // Back-pressure: queue fills, PC freezes at 4; a pop while full does not admit a push
    redirect(14'h000);
    ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, NOP, 14'(i + 1));
    ready = 1'b1;
    step(1'b1, NOP, 14'h005);
    step(1'b1, NOP, 14'h005);
    for (int i = 0; i < 5; i++) idle();

    // BTB/DIRP: two taken updates, tag match vs tag miss
    upd = 1'b1; upd_pc = 14'h010; upd_tgt = 14'h040; upd_taken = 1'b1;
    idle();
    idle();
    upd = 1'b0;
    redirect(14'h010);
    step(1'b1, BEQ, 14'h040);
    idle();
    redirect(14'h020);
    step(1'b1, BEQ, 14'h021);
    idle();
    upd = 1'b1; upd_taken = 1'b0;
    idle();
    upd = 1'b0;
    redirect(14'h010);
    step(1'b1, BNE, 14'h040);
    idle();
    // Second not-taken update lands together with a redirect
    upd = 1'b1;
    redirect(14'h010);
    upd = 1'b0;
    step(1'b1, BEQ, 14'h011);
    idle();
    // Update in the same cycle as the lookup: lookup sees the old (WEAK_NT) counter
    redirect(14'h010);
    upd = 1'b1; upd_taken = 1'b1;
    step(1'b1, BEQ, 14'h011);
    upd = 1'b0;
    idle();
    redirect(14'h010);
    step(1'b1, BEQ, 14'h040);
    idle();

    // Call/return, then 9 nested calls on an 8-deep RAS
    redirect(14'h005);
    step(1'b1, JAL | 32'h100, 14'h100);
    step(1'b1, JR, 14'h006);
    idle();
    redirect(14'h300);
    for (int i = 0; i < 9; i++) step(1'b1, JAL | (32'h301 + 32'(i)), 14'(14'h301 + i));
    step(1'b1, JR, 14'h309);
    step(1'b1, JR, 14'h308);
    idle();

    // Redirect with 3 entries queued and a hit in the same cycle
    ready = 1'b0;
    step(1'b1, NOP, 14'h309);
    step(1'b1, NOP, 14'h30A);
    step(1'b1, NOP, 14'h30B);
    take = 1'b1; res_pc = 14'h200; res_ras = m_top;
    step(1'b1, NOP, 14'h000);
    take = 1'b0;
    ready = 1'b1;
    idle();
    check("flush_addr", addr, 32'h800);

    // RAS top restore on redirect
    redirect(14'h500);
    step(1'b1, JAL | 32'h510, 14'h510);
    step(1'b1, JAL | 32'h520, 14'h520);
    idle();
    take = 1'b1; res_pc = 14'h600; res_ras = 3'd0;
    idle();
    take = 1'b0;
`ifdef FETCH_RAS_RESTORE_EN
    step(1'b1, JR, 14'h501);
`else
    step(1'b1, JR, 14'h511);
`endif
    idle();

    // Halt: REN drops, icache_halt sticks after halt is released
    halt = 1'b1;
    step(1'b1, NOP, 14'h000);
    check("ihalt_set", 32'(ihalt), 32'd1);
    halt = 1'b0;
    idle();
    check("ihalt_sticky", 32'(ihalt), 32'd1);

    // Reset mid-operation with an entry queued
    ready = 1'b0;
    step(1'b1, NOP, 14'(m_pc + 14'd1));
    nRST = 1'b0;
    #1;
    check("rst2_ivalid", 32'(ivalid), 32'd0);
    check("rst2_ihalt", 32'(ihalt), 32'd0);
    check("rst2_addr", addr, 32'd0);
    check("rst2_instr", instr_o, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    sb.delete();
    m_pc = '0;
    m_top = '0;
    ready = 1'b1;
    step(1'b1, NOP, 14'h001);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
